// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: shared state encoding and widths for the fetch sequencer
package fetch_sequencer_pkg;
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    WAIT_MEM = 2'd2,
    HALT     = 2'd3
  } state_t;
  localparam int BR_IMM_W  = 6;
  localparam int JMP_IMM_W = 12;
  localparam int STALL_W   = 16;
endpackage

// File: rtl/fetch_sequencer_sat_counter16.sv
// sat_counter16: saturating up-counter with enable and synchronous clear
//   clk, rst : clock and sync active-high reset
//   en       : count this cycle
//   clr      : zero the count (wins over en)
//   count    : current value, holds at all-ones
module sat_counter16
  import fetch_sequencer_pkg::*;
#(
  parameter int W = STALL_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count
);
  always_ff @(posedge clk)
    if (rst || clr) count <= '0;
    else if (en && !(&count)) count <= count + 1'b1;
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: sequences PC enable, redirects, flush bubbles, memory stalls and halt
//   inputs : clk_pi, reset_pi, clk_en_pi, decode status (branch/jump/halt + immediates),
//            mem_busy_pi, resume_pi
//   outputs: pc_en_po, branch/jump taken strobes, forwarded immediates, flush_po,
//            halted_po, fault_po, stall_count_po
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 15
) (
  input  logic                 clk_pi,
  input  logic                 reset_pi,
  input  logic                 clk_en_pi,
  input  logic                 is_branch_pi,
  input  logic                 branch_cond_pi,
  input  logic [BR_IMM_W-1:0]  branch_immediate_pi,
  input  logic                 is_jump_pi,
  input  logic [JMP_IMM_W-1:0] jump_immediate_pi,
  input  logic                 is_halt_pi,
  input  logic                 mem_busy_pi,
  input  logic                 resume_pi,
  output logic                 pc_en_po,
  output logic                 branch_taken_po,
  output logic [BR_IMM_W-1:0]  branch_immediate_po,
  output logic                 jump_taken_po,
  output logic [JMP_IMM_W-1:0] jump_immediate_po,
  output logic                 flush_po,
  output logic                 halted_po,
  output logic                 fault_po,
  output logic [STALL_W-1:0]   stall_count_po
);
  state_t     state, state_nx;
  logic [1:0] fcnt, fcnt_nx;
  logic [7:0] wcnt, wcnt_nx;
  logic       fault, fault_nx;
  logic       pc_en, br_tk, jmp_tk, flush, stall;
  logic       act;
  assign act = clk_en_pi & ~reset_pi;
  always_comb begin
    state_nx = state;
    fcnt_nx  = fcnt;
    wcnt_nx  = wcnt;
    fault_nx = fault;
    pc_en    = 1'b0;
    br_tk    = 1'b0;
    jmp_tk   = 1'b0;
    flush    = 1'b0;
    stall    = 1'b0;
    case (state)
      RUN:
        if (is_halt_pi) state_nx = HALT;
        else if (mem_busy_pi) begin
          stall    = 1'b1;
          state_nx = WAIT_MEM;
          wcnt_nx  = 8'd1;
        end else if (is_jump_pi || (is_branch_pi && branch_cond_pi)) begin
          pc_en    = 1'b1;
          jmp_tk   = is_jump_pi;
          br_tk    = ~is_jump_pi;
          state_nx = FLUSH;
          fcnt_nx  = 2'(FLUSH_CYCLES);
        end else pc_en = 1'b1;
      FLUSH: begin
        pc_en    = 1'b1;
        flush    = 1'b1;
        fcnt_nx  = fcnt - 2'd1;
        state_nx = (fcnt <= 2'd1) ? RUN : FLUSH;
      end
      WAIT_MEM: begin
        stall = 1'b1;
        if (!mem_busy_pi) state_nx = RUN;
        else if (wcnt == 8'(MEM_TIMEOUT)) begin
          fault_nx = 1'b1;
          state_nx = HALT;
        end else wcnt_nx = wcnt + 8'd1;
      end
      default:
        if (resume_pi) begin
          state_nx = RUN;
          fault_nx = 1'b0;
        end
    endcase
  end
  always_ff @(posedge clk_pi)
    if (reset_pi) begin
      state <= RUN;
      fcnt  <= '0;
      wcnt  <= '0;
      fault <= 1'b0;
    end else if (clk_en_pi) begin
      state <= state_nx;
      fcnt  <= fcnt_nx;
      wcnt  <= wcnt_nx;
      fault <= fault_nx;
    end
  sat_counter16 #(.W(STALL_W)) u_stall (
    .clk  (clk_pi),
    .rst  (reset_pi),
    .en   (act & stall),
    .clr  (1'b0),
    .count(stall_count_po)
  );
  assign pc_en_po            = act & pc_en;
  assign branch_taken_po     = act & br_tk;
  assign jump_taken_po       = act & jmp_tk;
  assign flush_po            = act & flush;
  assign halted_po           = ~reset_pi & (state == HALT);
  assign fault_po            = fault;
  assign branch_immediate_po = branch_immediate_pi;
  assign jump_immediate_po   = jump_immediate_pi;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: vector table with scoreboard plus hand sequences for flush depth and timeout
module tb_fetch_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, en, br, cond, jmp, halt, busy, resume;
  logic [5:0] bimm;
  logic [11:0] jimm;
  logic a_pc, a_bt, a_jt, a_fl, a_hl, a_ft, b_pc, b_bt, b_jt, b_fl, b_hl, b_ft;
  logic [5:0] a_bi, b_bi;
  logic [11:0] a_ji, b_ji;
  logic [15:0] a_sc, b_sc;
  int n = 0, errs = 0;
  fetch_sequencer #(.FLUSH_CYCLES(1), .MEM_TIMEOUT(15)) dut_a (
    .clk_pi(clk), .reset_pi(rst), .clk_en_pi(en), .is_branch_pi(br), .branch_cond_pi(cond),
    .branch_immediate_pi(bimm), .is_jump_pi(jmp), .jump_immediate_pi(jimm), .is_halt_pi(halt),
    .mem_busy_pi(busy), .resume_pi(resume), .pc_en_po(a_pc), .branch_taken_po(a_bt),
    .branch_immediate_po(a_bi), .jump_taken_po(a_jt), .jump_immediate_po(a_ji), .flush_po(a_fl),
    .halted_po(a_hl), .fault_po(a_ft), .stall_count_po(a_sc));
  fetch_sequencer #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(15)) dut_b (
    .clk_pi(clk), .reset_pi(rst), .clk_en_pi(en), .is_branch_pi(br), .branch_cond_pi(cond),
    .branch_immediate_pi(bimm), .is_jump_pi(jmp), .jump_immediate_pi(jimm), .is_halt_pi(halt),
    .mem_busy_pi(busy), .resume_pi(resume), .pc_en_po(b_pc), .branch_taken_po(b_bt),
    .branch_immediate_po(b_bi), .jump_taken_po(b_jt), .jump_immediate_po(b_ji), .flush_po(b_fl),
    .halted_po(b_hl), .fault_po(b_ft), .stall_count_po(b_sc));
  typedef struct {
    logic r, e, b, c;
    logic [5:0] bi;
    logic j;
    logic [11:0] ji;
    logic h, m, rs, pc, bt, jt, fl, hl, ft;
    logic [15:0] sc;
  } vec_t;
  vec_t tbl[$];
  vec_t sb[$];
  function automatic vec_t mkv(logic r, e, b, c, logic [5:0] bi, logic j, logic [11:0] ji,
                               logic h, m, rs, pc, bt, jt, fl, hl, ft, logic [15:0] sc);
    vec_t v;
    v.r = r; v.e = e; v.b = b; v.c = c; v.bi = bi; v.j = j; v.ji = ji; v.h = h; v.m = m; v.rs = rs;
    v.pc = pc; v.bt = bt; v.jt = jt; v.fl = fl; v.hl = hl; v.ft = ft; v.sc = sc;
    return v;
  endfunction
  task automatic chk(string name, int idx, logic [15:0] act, logic [15:0] exp);
    n++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask
  task automatic drive(vec_t t);
    rst = t.r; en = t.e; br = t.b; cond = t.c; bimm = t.bi; jmp = t.j; jimm = t.ji;
    halt = t.h; busy = t.m; resume = t.rs;
  endtask
  task automatic idle();
    rst = 0; en = 1; br = 0; cond = 0; bimm = 0; jmp = 0; jimm = 0; halt = 0; busy = 0; resume = 0;
  endtask
  task automatic next();
    @(posedge clk);
    #1;
  endtask
  initial begin
    vec_t e;
    //            r e b c bi     j ji       h m rs pc bt jt fl hl ft sc
    tbl.push_back(mkv(1,1,0,0,6'h00,0,12'h000,0,0,0, 0,0,0,0,0,0,16'd0));
    tbl.push_back(mkv(1,1,0,0,6'h00,0,12'h000,0,0,0, 0,0,0,0,0,0,16'd0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mkv(0,1,0,0,6'h00,0,12'h000,0,0,0, 1,0,0,0,0,0,16'd0));
    tbl.push_back(mkv(0,1,1,1,6'h3E,0,12'h000,0,0,0, 1,1,0,0,0,0,16'd0));
    tbl.push_back(mkv(0,1,1,1,6'h01,1,12'h123,1,1,0, 1,0,0,1,0,0,16'd0));
    tbl.push_back(mkv(0,1,0,0,6'h00,0,12'h000,0,0,0, 1,0,0,0,0,0,16'd0));
    tbl.push_back(mkv(0,1,1,0,6'h15,0,12'h000,0,0,0, 1,0,0,0,0,0,16'd0));
    tbl.push_back(mkv(0,1,1,1,6'h05,0,12'h000,0,1,0, 0,0,0,0,0,0,16'd0));
    tbl.push_back(mkv(0,1,1,1,6'h05,0,12'h000,0,1,0, 0,0,0,0,0,0,16'd1));
    tbl.push_back(mkv(0,1,1,1,6'h05,0,12'h000,0,1,0, 0,0,0,0,0,0,16'd2));
    tbl.push_back(mkv(0,1,1,1,6'h05,0,12'h000,0,0,0, 0,0,0,0,0,0,16'd3));
    tbl.push_back(mkv(0,1,1,1,6'h05,0,12'h000,0,0,0, 1,1,0,0,0,0,16'd4));
    tbl.push_back(mkv(0,1,0,0,6'h00,0,12'h000,0,0,0, 1,0,0,1,0,0,16'd4));
    tbl.push_back(mkv(0,0,0,0,6'h00,0,12'h000,1,0,0, 0,0,0,0,0,0,16'd4));
    tbl.push_back(mkv(0,1,0,0,6'h00,0,12'h000,1,0,0, 0,0,0,0,0,0,16'd4));
    tbl.push_back(mkv(0,1,0,0,6'h00,0,12'h000,0,0,0, 0,0,0,0,1,0,16'd4));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mkv(0,0,0,0,6'h00,0,12'h000,0,0,1, 0,0,0,0,1,0,16'd4));
    tbl.push_back(mkv(0,1,0,0,6'h00,0,12'h000,0,0,1, 0,0,0,0,1,0,16'd4));
    tbl.push_back(mkv(0,1,0,0,6'h00,0,12'h000,0,0,1, 1,0,0,0,0,0,16'd4));
    tbl.push_back(mkv(0,1,1,1,6'h11,1,12'hABC,0,0,0, 1,0,1,0,0,0,16'd4));
    tbl.push_back(mkv(0,0,0,0,6'h00,0,12'h000,0,0,0, 0,0,0,0,0,0,16'd4));
    tbl.push_back(mkv(0,1,0,0,6'h00,0,12'h000,0,0,0, 1,0,0,1,0,0,16'd4));
    tbl.push_back(mkv(0,1,0,0,6'h00,0,12'h000,0,0,0, 1,0,0,0,0,0,16'd4));
    tbl.push_back(mkv(0,1,0,0,6'h00,0,12'h000,0,1,0, 0,0,0,0,0,0,16'd4));
    tbl.push_back(mkv(1,1,0,0,6'h00,0,12'h000,0,1,0, 0,0,0,0,0,0,16'd5));
    tbl.push_back(mkv(0,1,0,0,6'h00,0,12'h000,0,0,0, 1,0,0,0,0,0,16'd0));
    idle();
    rst = 1;
    next();
    foreach (tbl[i]) begin
      drive(tbl[i]);
      sb.push_back(tbl[i]);
      @(negedge clk);
      e = sb.pop_front();
      chk("pc_en", i, 16'(a_pc), 16'(e.pc));
      chk("branch_taken", i, 16'(a_bt), 16'(e.bt));
      chk("jump_taken", i, 16'(a_jt), 16'(e.jt));
      chk("flush", i, 16'(a_fl), 16'(e.fl));
      chk("halted", i, 16'(a_hl), 16'(e.hl));
      chk("fault", i, 16'(a_ft), 16'(e.ft));
      chk("stall_count", i, a_sc, e.sc);
      chk("branch_imm", i, 16'(a_bi), 16'(e.bi));
      chk("jump_imm", i, a_ji, 16'(e.ji));
      next();
    end
    idle();
    rst = 1;
    next();
    rst = 0; jmp = 1; br = 1; cond = 1; jimm = 12'h5A5; bimm = 6'h2A;
    @(negedge clk);
    chk("b_jump_taken", 0, 16'(b_jt), 16'd1);
    chk("b_branch_taken", 0, 16'(b_bt), 16'd0);
    chk("b_pc_en", 0, 16'(b_pc), 16'd1);
    chk("b_jump_imm", 0, b_ji, 16'h5A5);
    next();
    idle();
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      chk("b_flush", k, 16'(b_fl), 16'd1);
      next();
    end
    @(negedge clk);
    chk("b_flush_end", 3, 16'(b_fl), 16'd0);
    chk("b_pc_en_end", 3, 16'(b_pc), 16'd1);
    next();
    rst = 1;
    next();
    rst = 0; busy = 1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("to_halted", k, 16'(a_hl), 16'd0);
      chk("to_pc_en", k, 16'(a_pc), 16'd0);
      next();
    end
    busy = 0; resume = 1;
    @(negedge clk);
    chk("to_halted", 16, 16'(a_hl), 16'd1);
    chk("to_fault", 16, 16'(a_ft), 16'd1);
    chk("to_stall_count", 16, a_sc, 16'd16);
    next();
    resume = 0;
    @(negedge clk);
    chk("resume_halted", 17, 16'(a_hl), 16'd0);
    chk("resume_fault", 17, 16'(a_ft), 16'd0);
    chk("resume_pc_en", 17, 16'(a_pc), 16'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
